piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out 8-bit serializer; the transmit-side counterpart of the team's serial-in shift register.
- Accepts a parallel word over a valid/ready handshake and shifts it out one bit per enabled clock, MSB-first or LSB-first.
- Sits between a parallel producer and any serial consumer (shift-register receiver, pin driver).
- Supports stalling, back-to-back frames and mid-frame abort by reset.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- CNT_W, 3, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  producer has a word on load_data.
- load_data  input  WIDTH  word to serialize.
- msb_first  input  1  1 = MSB first (left shift), 0 = LSB first (right shift); sampled on load accept.
- load_ready  output  1  serializer can accept a word this cycle.
- shift_en  input  1  consumer takes the current bit this cycle; 0 = stall.
- dout  output  1  current serial bit, registered.
- dout_valid  output  1  dout holds a valid frame bit.
- last  output  1  dout is the final bit of the frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE; shift register, counter and direction flag cleared.
  - dout=0, dout_valid=0, last=0, busy=0.
  - load_ready is forced 0 while reset is high.
- States: IDLE, SHIFT, plus PARITY (only when the optional feature is compiled in).
- Accept: load_valid & load_ready at a rising edge.
  - Captures load_data and msb_first; counter=0; state=SHIFT.
  - Next cycle: dout = first bit (bit WIDTH-1 if msb_first, else bit 0); dout_valid=1; busy=1.
  - Latency is one cycle from accept to first bit.
- load_ready (combinational) = ~reset & (IDLE | (final bit showing & shift_en)). This gives gapless back-to-back frames.
- SHIFT:
  - shift_en=1 and not final: shift register moves by one position in the captured direction; counter increments; next bit appears on dout the following cycle.
  - shift_en=0: dout, counter, register and last all hold; no bit is lost or repeated.
- last = 1 while counter == WIDTH-1 (final data bit) in SHIFT, with PARITY_EN off.
- Final bit with shift_en=1:
  - If a word is accepted in the same cycle: reload, counter=0, stay in SHIFT; first bit of the new word appears next cycle.
  - Otherwise: go to IDLE; dout_valid=0, busy=0, last=0, dout=0 the next cycle.
- load_valid in SHIFT before the final bit: ignored (load_ready=0). The producer must hold the word.
- msb_first changes mid-frame have no effect on the current frame.
- Reset mid-frame: frame aborted; no further bits of that word are emitted after reset deasserts.
- Counter never wraps past WIDTH-1; unused counter values are unreachable.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the final data bit is taken (shift_en=1), enter PARITY for one bit slot.
  - dout = even parity (XOR) of the captured word; dout_valid=1; last=1 only in PARITY, not on the final data bit.
  - PARITY holds under shift_en=0.
  - load_ready in PARITY follows shift_en; back-to-back reload applies from PARITY.
  - Frame length is WIDTH+1 bits.
- Undefined: PARITY state absent; frame is WIDTH bits; last asserts on the final data bit.

Test Plan:
- Reset, then load 8'hA5 with msb_first=1 and shift_en=1 throughout -> dout 1,0,1,0,0,1,0,1 on cycles 1-8 after accept; last only on cycle 8; dout_valid and busy drop on cycle 9.
- Load 8'h01 with msb_first=0 -> dout 1,0,0,0,0,0,0,0; load_ready=0 on cycles 1-7, 1 on cycle 8 (shift_en=1).
- Load 8'hC3 MSB-first; drop shift_en for 3 cycles after the 2nd bit -> dout holds 1 for 3 extra cycles; full sequence 1,1,0,0,0,0,1,1 intact; total frame 11 cycles.
- Load 8'hF0 then 8'h0F presented with load_valid high continuously -> 16 contiguous valid bits 1111000000001111; no idle cycle; last on bits 8 and 16.
- Load 8'hFF; assert reset asynchronously after 3 bits -> dout, dout_valid, busy go 0 immediately; after release, state IDLE with load_ready=1 and no residual bits.
- PISO_PARITY_EN defined: load 8'h07 MSB-first -> 0,0,0,0,0,1,1,1 then parity 1; last only on the 9th bit.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out word serializer.
//
// A word is accepted over a load_valid/load_ready handshake and shifted out
// one bit per clock with shift_en high, MSB-first or LSB-first as selected by
// msb_first at accept time. The first bit appears one cycle after accept.
// Accepting a new word while the final bit is being taken gives gapless
// back-to-back frames.
//
// Optional feature (macro PISO_PARITY_EN): one extra bit slot after the data
// carrying the even parity (XOR) of the word; last then marks the parity bit.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   load_valid  producer has a word on load_data
//   load_data   word to serialize (WIDTH bits)
//   msb_first   1 = MSB first, 0 = LSB first; sampled on accept
//   load_ready  serializer can accept a word this cycle (combinational)
//   shift_en    consumer takes the current bit this cycle; 0 = stall
//   dout        current serial bit (registered)
//   dout_valid  dout holds a valid frame bit
//   last        dout is the final bit of the frame
//   busy        a frame is in progress
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             dir;      // captured msb_first for the current frame
`ifdef PISO_PARITY_EN
  logic             par;      // even parity of the captured word
`endif

  logic             final_data;
  logic             final_slot;
  logic             accept;
  logic [WIDTH-1:0] sreg_nxt;
  logic             bit_nxt;

  assign final_data = (state == ST_SHIFT) && (cnt == CNT_LAST);
`ifdef PISO_PARITY_EN
  assign final_slot = (state == ST_PARITY);
`else
  assign final_slot = final_data;
`endif

  // Ready while idle, or while the last bit of a frame is being taken, so a
  // waiting word follows with no idle cycle.
  assign load_ready = ~reset & ((state == ST_IDLE) | (final_slot & shift_en));
  assign accept     = load_valid & load_ready;

  // The bit that becomes visible after this shift is the neighbour of the
  // one currently on dout, in the captured direction.
  assign sreg_nxt = dir ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign bit_nxt  = dir ? sreg[WIDTH-2] : sreg[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      dir        <= 1'b0;
`ifdef PISO_PARITY_EN
      par        <= 1'b0;
`endif
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
    end else if (accept) begin
      state      <= ST_SHIFT;
      sreg       <= load_data;
      cnt        <= '0;
      dir        <= msb_first;
`ifdef PISO_PARITY_EN
      par        <= ^load_data;
`endif
      dout       <= msb_first ? load_data[WIDTH-1] : load_data[0];
      dout_valid <= 1'b1;
      last       <= 1'b0;
      busy       <= 1'b1;
    end else if (shift_en && state == ST_SHIFT && !final_data) begin
      sreg <= sreg_nxt;
      cnt  <= cnt + 1'b1;
      dout <= bit_nxt;
`ifdef PISO_PARITY_EN
      last <= 1'b0;
`else
      last <= (cnt == CNT_PEN);
`endif
`ifdef PISO_PARITY_EN
    end else if (shift_en && final_data) begin
      state <= ST_PARITY;
      dout  <= par;
      last  <= 1'b1;
`endif
    end else if (shift_en && final_slot) begin
      // Frame done and nothing waiting: drop back to idle.
      state      <= ST_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer. A negedge monitor keeps a
// scoreboard of expected {bit, last} pairs pushed whenever a word is accepted
// and popped whenever the consumer takes a bit.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         msb_first = 1'b0;
  logic         shift_en = 1'b1;
  logic         load_ready, dout, dout_valid, last, busy;

  logic [1:0] sb[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .msb_first(msb_first), .load_ready(load_ready), .shift_en(shift_en),
    .dout(dout), .dout_valid(dout_valid), .last(last), .busy(busy)
  );

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    logic [1:0] e;
    if (dout_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: dout_valid=1 dout=%0b with no bit expected", dout);
      end else begin
        e = sb[0];
        if ({dout, last} !== e) begin
          n_err++;
          $display("FAIL sb_bit: {dout,last}=%b required %b (%0d left)", {dout, last}, e, sb.size());
        end
        if (shift_en) void'(sb.pop_front());
      end
    end else begin
      n_vec++;
      if ({dout, last, busy} !== 3'b000 || sb.size() != 0) begin
        n_err++;
        $display("FAIL idle_out: {dout,last,busy}=%b pending=%0d required 000 and 0", {dout, last, busy}, sb.size());
      end
    end
    n_vec++;
    if (busy !== dout_valid) begin
      n_err++;
      $display("FAIL busy_vs_valid: busy=%b required %b", busy, dout_valid);
    end
    if (load_valid && load_ready) begin
      for (int i = 0; i < W; i++)
        sb.push_back({msb_first ? load_data[W-1-i] : load_data[i], `ifdef PISO_PARITY_EN 1'b0 `else (i == W-1) `endif});
`ifdef PISO_PARITY_EN
      sb.push_back({^load_data, 1'b1});
`endif
    end
  end

  // Present a word and return at the start of cycle 1 after accept.
  task automatic load_word(input logic [W-1:0] d, input logic m);
    int t;
    load_data = d; msb_first = m; load_valid = 1'b1;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (load_ready) break;
    end
    n_vec++;
    if (t == 40) begin
      n_err++;
      $display("FAIL load_accept: load_ready=0 for 40 cycles, required 1");
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    msb_first = ~m;  // must not affect the frame in flight
  endtask

  // Run the frame to completion; mode 0 = always take, 1 = stall cycles 2-4,
  // 2 = random stalls. Returns the number of cycles dout_valid was high.
  task automatic run_frame(input int mode, output int cnt);
    cnt = 0;
    for (int c = 1; c < 100; c++) begin
      case (mode)
        0:       shift_en = 1'b1;
        1:       shift_en = !(c >= 2 && c <= 4);
        default: shift_en = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (!dout_valid) break;
      cnt++;
      @(posedge clk); #1;
    end
    shift_en = 1'b1;
  endtask

  task automatic test_reset();
    load_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({dout, dout_valid, last, busy, load_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_state: {dout,valid,last,busy,ready}=%b required 00000", {dout, dout_valid, last, busy, load_ready});
    end
    @(posedge clk); #1;
    reset = 1'b0; load_valid = 1'b0;
    #1;
    n_vec++;
    if (load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: load_ready=%b required 1", load_ready);
    end
  endtask

  task automatic test_msb_a5();
    int cnt;
    load_word(8'hA5, 1'b1);
    run_frame(0, cnt);
    n_vec++;
    if (cnt != FRAME) begin
      n_err++;
      $display("FAIL a5_frame_len: %0d cycles required %0d", cnt, FRAME);
    end
  endtask

  task automatic test_lsb_01();
    load_word(8'h01, 1'b0);
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      n_vec++;
      if (load_ready !== (c == FRAME)) begin
        n_err++;
        $display("FAIL lsb01_ready: cycle %0d load_ready=%b required %b", c, load_ready, c == FRAME);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_vec++;
    if (dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lsb01_end: dout_valid=%b required 0", dout_valid);
    end
  endtask

  task automatic test_stall();
    int cnt;
    load_word(8'hC3, 1'b1);
    run_frame(1, cnt);
    n_vec++;
    if (cnt != FRAME + 3) begin
      n_err++;
      $display("FAIL stall_frame_len: %0d cycles required %0d", cnt, FRAME + 3);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    bit got2;
    shift_en = 1'b1;
    load_data = 8'hF0; msb_first = 1'b1; load_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (load_ready) break;
    end
    @(posedge clk); #1;
    load_data = 8'h0F;
    cnt = 0; got2 = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!dout_valid) break;
      cnt++;
      if (load_ready && load_valid) got2 = 1;
      @(posedge clk); #1;
      if (got2) load_valid = 1'b0;
    end
    load_valid = 1'b0;
    n_vec++;
    if (cnt != 2 * FRAME || !got2) begin
      n_err++;
      $display("FAIL b2b_contiguous: %0d valid cycles (second accepted=%0b) required %0d and 1", cnt, got2, 2 * FRAME);
    end
  endtask

  task automatic test_abort();
    shift_en = 1'b1;
    load_word(8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    sb.delete();
    #1;
    n_vec++;
    if ({dout, dout_valid, last, busy, load_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL abort_immediate: {dout,valid,last,busy,ready}=%b required 00000", {dout, dout_valid, last, busy, load_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_vec++;
    if (load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_ready: load_ready=%b required 1", load_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (dout_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_residual: cycle %0d dout_valid=%b required 0", c, dout_valid);
      end
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    int cnt;
    load_word(8'h07, 1'b1);
    run_frame(0, cnt);
    n_vec++;
    if (cnt != W + 1) begin
      n_err++;
      $display("FAIL parity_frame_len: %0d cycles required %0d", cnt, W + 1);
    end
  endtask
`endif

  task automatic test_random();
    int cnt;
    for (int k = 0; k < 6; k++) begin
      load_word(W'($urandom), 1'($urandom_range(0, 1)));
      run_frame(2, cnt);
      n_vec++;
      if (cnt < FRAME) begin
        n_err++;
        $display("FAIL random_frame_len: word %0d %0d cycles required >= %0d", k, cnt, FRAME);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_a5();
    test_lsb_01();
    test_stall();
    test_back_to_back();
    test_abort();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    test_random();
    @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d bits still expected, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
